// File: rtl/global_tick_gen.sv
// Two programmable down-counting dividers producing subsystem clock-event strobes,
// merged into a global event strobe with a wrapping event counter.
module global_tick_gen #(
    parameter int unsigned       CNT_W    = 16,
    parameter int unsigned       TCNT_W   = 32,
    parameter logic [CNT_W-1:0]  DIV1_RST = '0,
    parameter logic [CNT_W-1:0]  DIV2_RST = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              load_req_i,
    input  logic [CNT_W-1:0]  div1_i,
    input  logic [CNT_W-1:0]  div2_i,
    output logic              load_ack_o,
    output logic              tick1_o,
    output logic              tick2_o,
    output logic              gtick_o,
    output logic              both_o,
    output logic [TCNT_W-1:0] gtick_cnt_o
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                run_step;
    logic [1:0]          tick_d_vec;
    logic [1:0]          tick_q_vec;
    logic                ack_q, ack_d;
    logic                gtick_q, gtick_d;
    logic                both_q, both_d;
    logic [TCNT_W-1:0]   gcnt_q, gcnt_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: if (en_i)  state_d = ST_RUN;
            ST_RUN:  if (!en_i) state_d = ST_STOP;
            default:            state_d = ST_STOP;
        endcase
    end

    // Dividers step on every edge that lands in RUN, so a one-cycle en_i pulse
    // advances each counter exactly once.
    assign run_step = (state_d == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : gen_div
        localparam logic [CNT_W-1:0] RST_V = (gi == 0) ? DIV1_RST : DIV2_RST;

        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] din;
        logic             tick_q, tick_d;

        assign din = (gi == 0) ? div1_i : div2_i;

        // A load wins over counting and keeps the strobe low while held.
        always_comb begin
            div_d  = div_q;
            cnt_d  = cnt_q;
            tick_d = 1'b0;
            if (load_req_i) begin
                div_d = din;
                cnt_d = din;
            end else if (run_step) begin
                if (cnt_q == '0) begin
                    cnt_d  = div_q;
                    tick_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                div_q  <= RST_V;
                cnt_q  <= RST_V;
                tick_q <= 1'b0;
            end else begin
                div_q  <= div_d;
                cnt_q  <= cnt_d;
                tick_q <= tick_d;
            end
        end

        assign tick_d_vec[gi] = tick_d;
        assign tick_q_vec[gi] = tick_q;
    end

    // Merged strobes are computed from next-state ticks so every output stays a flop.
    always_comb begin
        ack_d   = load_req_i;
        gtick_d = |tick_d_vec;
        both_d  = &tick_d_vec;
        gcnt_d  = gcnt_q + {{(TCNT_W-1){1'b0}}, gtick_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            gtick_q <= 1'b0;
            both_q  <= 1'b0;
            gcnt_q  <= '0;
        end else begin
            ack_q   <= ack_d;
            gtick_q <= gtick_d;
            both_q  <= both_d;
            gcnt_q  <= gcnt_d;
        end
    end

    assign load_ack_o  = ack_q;
    assign tick1_o     = tick_q_vec[0];
    assign tick2_o     = tick_q_vec[1];
    assign gtick_o     = gtick_q;
    assign both_o      = both_q;
    assign gtick_cnt_o = gcnt_q;

endmodule
